// File: rtl/distance_bcd_conv.sv
// Binary-to-packed-BCD converter for ranging distances (13-bit mm -> 4 BCD digits),
// sequential double-dabble with a 1-deep pending slot. Optional DIST_AVG4_EN adds a 4-sample moving average.
module distance_bcd_conv #(
  parameter logic [12:0] MAX_DIST_MM = 13'd4000,
  parameter logic [3:0]  SHIFT_CNT   = 4'd13
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [12:0] data_bin,
  input  logic        data_valid,
  output logic [15:0] bcd_data,
  output logic        bcd_valid,
  output logic        over_range,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [12:0] shift_reg;
  logic [12:0] cap_val;
  logic [12:0] pend_val;
  logic        pend_flag;
  logic [15:0] acc;
  logic [15:0] acc_adj;
  logic [3:0]  iter_cnt;
  logic        conv_strobe;
  logic [12:0] conv_data;
  logic [12:0] load_val;

`ifdef DIST_AVG4_EN
  logic [12:0] hist0, hist1, hist2;
  logic        hist_primed;
  logic [14:0] sum_new;
  logic [12:0] avg_data;
  logic        avg_valid;

  assign sum_new = {2'b00, data_bin} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};

  // The first sample after reset seeds the whole history so the average starts at that value.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hist0       <= '0;
      hist1       <= '0;
      hist2       <= '0;
      hist_primed <= 1'b0;
      avg_data    <= '0;
      avg_valid   <= 1'b0;
    end else begin
      avg_valid <= data_valid;
      if (data_valid) begin
        if (!hist_primed) begin
          hist0       <= data_bin;
          hist1       <= data_bin;
          hist2       <= data_bin;
          avg_data    <= data_bin;
          hist_primed <= 1'b1;
        end else begin
          hist0    <= data_bin;
          hist1    <= hist0;
          hist2    <= hist1;
          avg_data <= sum_new[14:2];
        end
      end
    end
  end

  assign conv_strobe = avg_valid;
  assign conv_data   = avg_data;
`else
  assign conv_strobe = data_valid;
  assign conv_data   = data_bin;
`endif

  function automatic logic [15:0] add3(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign acc_adj = add3(acc);
  // A strobe arriving in DONE is newer than any pending sample, so it wins.
  assign load_val = conv_strobe ? conv_data : pend_val;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      cap_val    <= '0;
      pend_val   <= '0;
      pend_flag  <= 1'b0;
      acc        <= '0;
      iter_cnt   <= '0;
      bcd_data   <= '0;
      bcd_valid  <= 1'b0;
      over_range <= 1'b0;
      busy       <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      busy      <= (state != IDLE);
      case (state)
        IDLE: begin
          if (conv_strobe) begin
            shift_reg <= conv_data;
            cap_val   <= conv_data;
            acc       <= '0;
            iter_cnt  <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, shift_reg} <= {acc_adj[14:0], shift_reg, 1'b0};
          if (conv_strobe) begin
            pend_val  <= conv_data;
            pend_flag <= 1'b1;
          end
          if (iter_cnt == SHIFT_CNT - 4'd1) state <= DONE;
          else iter_cnt <= iter_cnt + 4'd1;
        end
        DONE: begin
          bcd_data   <= acc;
          over_range <= (cap_val > MAX_DIST_MM);
          bcd_valid  <= 1'b1;
          pend_flag  <= 1'b0;
          if (conv_strobe || pend_flag) begin
            shift_reg <= load_val;
            cap_val   <= load_val;
            acc       <= '0;
            iter_cnt  <= '0;
            state     <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_distance_bcd_conv.sv
// Directed bench for distance_bcd_conv: a timing/arithmetic model checked every cycle,
// plus a queue of hand-computed BCD results checked on each bcd_valid.
module tb_distance_bcd_conv;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [12:0] data_bin = '0;
  logic        data_valid = 1'b0;
  logic [15:0] bcd_data;
  logic        bcd_valid;
  logic        over_range;
  logic        busy;

  always #10 sys_clk = ~sys_clk;

  distance_bcd_conv dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data_bin  (data_bin),
    .data_valid(data_valid),
    .bcd_data  (bcd_data),
    .bcd_valid (bcd_valid),
    .over_range(over_range),
    .busy      (busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sent_cyc = 0;
  int last_valid_cyc = -1;
  int prev_valid_cyc = -1;
  logic [16:0] exp_q[$];

  // model state
  bit          m_active = 0;
  int          m_done_at = 0;
  int          m_cur = 0;
  bit          m_pend = 0;
  int          m_pend_val = 0;
  logic [15:0] m_bcd = '0;
  bit          m_over = 0;
  bit          m_valid = 0;
  bit          m_busy = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic m_start(input int v);
    m_active  = 1;
    m_done_at = cyc + 14;
    m_cur     = v;
  endtask

  task automatic model_step(input bit dv, input int din);
    m_busy  = m_active;
    m_valid = 0;
    if (m_active && cyc == m_done_at) begin
      m_valid = 1;
      m_bcd   = to_bcd(m_cur);
      m_over  = (m_cur > 4000);
      if (dv) m_start(din);
      else if (m_pend) m_start(m_pend_val);
      else m_active = 0;
      m_pend = 0;
    end else if (m_active) begin
      if (dv) begin
        m_pend     = 1;
        m_pend_val = din;
      end
    end else if (dv) begin
      m_start(din);
    end
  endtask

  // compare process: one check set per cycle, #1 after the active edge
  always @(posedge sys_clk) begin
    logic [16:0] lit;
    cyc++;
    if (!sys_rst_n) begin
      m_active = 0; m_pend = 0; m_bcd = '0; m_over = 0; m_valid = 0; m_busy = 0;
    end else begin
      model_step(data_valid, int'(data_bin));
    end
    #1;
    check("bcd_valid", int'(bcd_valid), int'(m_valid));
    check("busy", int'(busy), int'(m_busy));
    check("bcd_data", int'(bcd_data), int'(m_bcd));
    check("over_range", int'(over_range), int'(m_over));
    if (bcd_valid === 1'b1) begin
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_result", int'({over_range, bcd_data}), -1);
      end else begin
        lit = exp_q.pop_front();
        check("literal_result", int'({over_range, bcd_data}), int'(lit));
      end
    end
  end

  task automatic send(input int v);
    data_bin   = 13'(v);
    data_valid = 1'b1;
    @(negedge sys_clk);
    sent_cyc   = cyc;
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (!m_active) break;
    end
    check("idle_timeout", int'(m_active), 0);
    repeat (2) @(negedge sys_clk);
  endtask

  initial begin
    int s100;
    repeat (3) @(negedge sys_clk);
    check("rst_bcd_data", int'(bcd_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_bcd_valid", int'(bcd_valid), 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    exp_q.push_back({1'b0, 16'h1234});
    send(1234);
    wait_idle();
    check("latency_1234", last_valid_cyc - sent_cyc, 14);

    exp_q.push_back({1'b0, 16'h0000}); send(0);    wait_idle();
    exp_q.push_back({1'b0, 16'h0009}); send(9);    wait_idle();
    exp_q.push_back({1'b0, 16'h0010}); send(10);   wait_idle();
    exp_q.push_back({1'b1, 16'h8191}); send(8191); wait_idle();

    // 200 is overwritten by 300 while the 100 conversion runs
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b0, 16'h0300});
    send(100);
    s100 = sent_cyc;
    repeat (2) @(negedge sys_clk);
    send(200);
    @(negedge sys_clk);
    send(300);
    wait_idle();
    check("overlap_first_latency", prev_valid_cyc - s100, 14);
    check("overlap_gap", last_valid_cyc - prev_valid_cyc, 14);

    exp_q.push_back({1'b0, 16'h4000}); send(4000); wait_idle();
    exp_q.push_back({1'b1, 16'h4001}); send(4001); wait_idle();

    // reset mid-conversion: outputs clear at once, no result for 555
    send(555);
    repeat (6) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_bcd_data", int'(bcd_data), 0);
    check("async_rst_over", int'(over_range), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_valid", int'(bcd_valid), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    exp_q.push_back({1'b0, 16'h0077});
    send(77);
    wait_idle();
    check("latency_after_rst", last_valid_cyc - sent_cyc, 14);

    check("results_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/distance_bcd_conv.md
Name: distance_bcd_conv

Overview:
- Downstream stage of the ultrasonic ranging controller.
- Takes each new 13-bit distance in mm plus its one-cycle valid strobe (the controller's delayed fall flag).
- Converts the binary value to 4-digit packed BCD with a sequential shift-add-3 (double-dabble) FSM.
- Presents the BCD digits, a one-cycle done strobe and a range flag to the seven-segment display driver.

Parameters:
- MAX_DIST_MM, 13'd4000: distance above which over_range is raised; the result is still converted.
- SHIFT_CNT, 4'd13: number of shift iterations, equal to the input width; fixed for 13-bit input.

Ports:
- sys_clk, input, 1: 50 MHz system clock.
- sys_rst_n, input, 1: asynchronous, active-low reset.
- data_bin, input, 13: distance in mm, unsigned, 0..8191.
- data_valid, input, 1: one-cycle strobe; data_bin is valid in the same cycle.
- bcd_data, output, 16: {thousands, hundreds, tens, ones}, 4 bits each; held until the next conversion.
- bcd_valid, output, 1: one-cycle pulse when bcd_data updates.
- over_range, output, 1: registered with bcd_data; 1 when the converted value > MAX_DIST_MM.
- busy, output, 1: high while a conversion is in progress.

Behaviour:
- Reset (async): bcd_data=16'h0000, bcd_valid=0, over_range=0, busy=0, FSM=IDLE, pending flag cleared, all internal shift registers zero.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On data_valid=1, capture data_bin into a 13-bit shift register and clear the 16-bit BCD accumulator.
  - Load iteration counter 0, go to SHIFT; busy=1 from the next cycle.
- SHIFT, one iteration per cycle:
  - For each BCD nibble >= 5, add 3 to it.
  - Then shift {accumulator, shift_reg} left by 1.
  - After iteration SHIFT_CNT-1 (the 13th), go to DONE.
- DONE, one cycle:
  - Register bcd_data from the accumulator.
  - over_range = (captured value > MAX_DIST_MM).
  - Pulse bcd_valid=1.
  - Go to IDLE, or directly to SHIFT if a pending sample exists.
- Latency:
  - data_valid sampled at edge k; bcd_valid and the new bcd_data are visible after edge k+14.
  - Exactly 14 cycles; busy=1 after edges k+1..k+14 inclusive.
- data_valid while busy:
  - The sample is stored in a 1-deep pending register; a later strobe overwrites it, so the newest value wins.
  - On leaving DONE, the pending sample is loaded as if in IDLE and the pending flag is cleared.
  - No sample is silently lost except overwritten pendings.
- data_valid in the same cycle as DONE: treated as pending and started immediately; a back-to-back bcd_valid gap of 14 cycles.
- Arithmetic:
  - Max input 8191 → BCD 8191; no overflow within 4 digits; nibbles never exceed 9 after conversion.
- Boundaries:
  - Input 0 → 16'h0000.
  - Input 4000 → over_range=0.
  - Input 4001 → over_range=1.
- bcd_valid is never asserted for more than one consecutive cycle.
- Reset mid-conversion aborts; outputs return to reset values and the pending sample is discarded.

Optional Feature:
- Macro: DIST_AVG4_EN.
- Defined:
  - A 4-entry moving average is placed in front of the converter; each data_valid shifts data_bin into the history.
  - Value converted = (sum of 4 entries) >> 2, floor; the sum is a 15-bit adder.
  - The first data_valid after reset fills all 4 entries with that sample.
  - The averaging register adds 1 cycle: latency 15 cycles.
  - over_range is judged on the averaged value.
- Undefined:
  - The raw data_bin is converted; latency 14; no history storage.

Test Plan:
- Reset release, data_bin=1234 with data_valid at edge k → bcd_valid pulse after edge k+14, bcd_data=16'h1234, over_range=0, busy low afterward.
- Inputs 0, 9, 10, 8191 each in isolation → 16'h0000, 16'h0009, 16'h0010, 16'h8191; bcd_valid one cycle wide each time.
- Inputs 4000 then 4001 → over_range 0 then 1, bcd 16'h4000 then 16'h4001.
- Input 100 at k, then 200 at k+3 and 300 at k+5 while busy → results 16'h0100 then 16'h0300 (200 overwritten); second bcd_valid 14 cycles after the first.
- Assert sys_rst_n=0 at k+7 mid-conversion → all outputs 0 immediately; no bcd_valid; next valid converts normally.
- DIST_AVG4_EN: first sample 400, then 800, 800, 800 → averaged outputs 0400, 0500, 0600, 0700, each 15 cycles after its strobe.
